// File: rtl/vga_fill_pkg.sv
// Shared types and constants for the framebuffer rectangle-fill initiator.
// Contents:
//   fill_state_t : FSM state encoding (IDLE, SETUP, WRITE, DONE)
//   fill_cmd_t   : rectangle command (two corners plus fill colour)
//   FULL_BE      : all-ones Avalon byteenable for a full-pixel write
package vga_fill_pkg;

    localparam int FILL_XW = 10;
    localparam int FILL_YW = 10;
    localparam int FILL_DW = 16;

    localparam logic [FILL_DW/8-1:0] FULL_BE = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

    typedef struct packed {
        logic [FILL_XW-1:0] x0;
        logic [FILL_YW-1:0] y0;
        logic [FILL_XW-1:0] x1;
        logic [FILL_YW-1:0] y1;
        logic [FILL_DW-1:0] color;
    } fill_cmd_t;

endpackage

// File: rtl/vga_fill_clip.sv
// Combinational normalise-and-clip of a rectangle-fill command.
// Ports:
//   i_cmd : raw command, corners in any order
//   o_cmd : normalised command; x0/y0 hold the minimum corner, x1/y1 the
//           maximum corner clipped to the last visible column/row.
// The minimum corner is not clipped, so an off-screen start is still
// visible to the caller, which skips the fill in that case.
module vga_fill_clip
    import vga_fill_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  fill_cmd_t i_cmd,
    output fill_cmd_t o_cmd
);

    localparam logic [FILL_XW-1:0] X_LAST = FILL_XW'(H_RES - 1);
    localparam logic [FILL_YW-1:0] Y_LAST = FILL_YW'(V_RES - 1);

    logic [FILL_XW-1:0] w_xa;
    logic [FILL_XW-1:0] w_xb;
    logic [FILL_YW-1:0] w_ya;
    logic [FILL_YW-1:0] w_yb;

    // Order the corners, then clip the far corner to the visible area.
    always_comb begin
        if (i_cmd.x0 < i_cmd.x1) begin
            w_xa = i_cmd.x0;
            w_xb = i_cmd.x1;
        end else begin
            w_xa = i_cmd.x1;
            w_xb = i_cmd.x0;
        end
        if (i_cmd.y0 < i_cmd.y1) begin
            w_ya = i_cmd.y0;
            w_yb = i_cmd.y1;
        end else begin
            w_ya = i_cmd.y1;
            w_yb = i_cmd.y0;
        end
        o_cmd.x0    = w_xa;
        o_cmd.y0    = w_ya;
        o_cmd.x1    = (w_xb > X_LAST) ? X_LAST : w_xb;
        o_cmd.y1    = (w_yb > Y_LAST) ? Y_LAST : w_yb;
        o_cmd.color = i_cmd.color;
    end

endmodule

// File: rtl/vga_framebuffer_fill_master.sv
// Avalon-MM write initiator that fills a rectangle of the framebuffer with
// one colour, one single-beat write per pixel in raster order.
// Ports:
//   sys_clk, sys_rst             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready          : command handshake (accepted only in IDLE)
//   cmd_x0/y0/x1/y1, cmd_color   : rectangle corners (any order) and colour
//   busy, done, pixel_count      : status; done pulses once per command
//   framebuffer_avn_*            : Avalon-MM master, write-only
module vga_framebuffer_fill_master
    import vga_fill_pkg::*;
#(
    parameter int AVN_AW = 18,
    parameter int AVN_DW = 16,
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int XW     = 10,
    parameter int YW     = 10
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [XW-1:0]         cmd_x0,
    input  logic [YW-1:0]         cmd_y0,
    input  logic [XW-1:0]         cmd_x1,
    input  logic [YW-1:0]         cmd_y1,
    input  logic [AVN_DW-1:0]     cmd_color,
    output logic                  busy,
    output logic                  done,
    output logic [AVN_AW-1:0]     pixel_count,
    output logic                  framebuffer_avn_write,
    output logic                  framebuffer_avn_read,
    output logic [AVN_AW-1:0]     framebuffer_avn_address,
    output logic [AVN_DW-1:0]     framebuffer_avn_writedata,
    output logic [AVN_DW/8-1:0]   framebuffer_avn_byteenable,
    input  logic                  framebuffer_avn_waitrequest
);

    localparam logic [XW-1:0]     X_RES_W = XW'(H_RES);
    localparam logic [YW-1:0]     Y_RES_W = YW'(V_RES);
    localparam logic [AVN_AW-1:0] H_RES_A = AVN_AW'(H_RES);

    fill_state_t         r_state;
    fill_state_t         w_state_nxt;
    fill_cmd_t           r_cmd;
    fill_cmd_t           w_cmd_nxt;
    fill_cmd_t           w_cmd_raw;
    fill_cmd_t           w_cmd_clip;
    logic [XW-1:0]       r_x;
    logic [XW-1:0]       w_x_nxt;
    logic [YW-1:0]       r_y;
    logic [YW-1:0]       w_y_nxt;
    logic [AVN_AW-1:0]   r_row_base;
    logic [AVN_AW-1:0]   w_row_nxt;
    logic                r_write;
    logic                w_write_nxt;
    logic [AVN_AW-1:0]   r_addr;
    logic [AVN_AW-1:0]   w_addr_nxt;
    logic [AVN_DW-1:0]   r_wdata;
    logic [AVN_DW-1:0]   w_wdata_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_cmd_ready;
    logic                w_cmd_ready_nxt;
    logic [AVN_AW-1:0]   r_pix_cnt;
    logic [AVN_AW-1:0]   w_pix_cnt_nxt;

    // Gather the command ports into one struct for the normaliser.
    always_comb begin
        w_cmd_raw.x0    = cmd_x0;
        w_cmd_raw.y0    = cmd_y0;
        w_cmd_raw.x1    = cmd_x1;
        w_cmd_raw.y1    = cmd_y1;
        w_cmd_raw.color = cmd_color;
    end

    vga_fill_clip #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_clip (
        .i_cmd (w_cmd_raw),
        .o_cmd (w_cmd_clip)
    );

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_row_nxt       = r_row_base;
        w_write_nxt     = r_write;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_cmd_ready_nxt = r_cmd_ready;
        w_pix_cnt_nxt   = r_pix_cnt;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_nxt       = w_cmd_clip;
                    w_pix_cnt_nxt   = '0;
                    w_busy_nxt      = 1'b1;
                    w_cmd_ready_nxt = 1'b0;
                    w_state_nxt     = ST_SETUP;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if ((r_cmd.x0 >= X_RES_W) || (r_cmd.y0 >= Y_RES_W)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    // The only multiply; later rows step the base by H_RES.
                    w_row_nxt   = AVN_AW'(r_cmd.y0) * H_RES_A;
                    w_x_nxt     = r_cmd.x0;
                    w_y_nxt     = r_cmd.y0;
                    w_addr_nxt  = w_row_nxt + AVN_AW'(r_cmd.x0);
                    w_wdata_nxt = r_cmd.color;
                    w_write_nxt = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // A stalled beat keeps address, data and write unchanged.
                if (!framebuffer_avn_waitrequest) begin
                    w_pix_cnt_nxt = r_pix_cnt + {{(AVN_AW-1){1'b0}}, 1'b1};
                    if ((r_x == r_cmd.x1) && (r_y == r_cmd.y1)) begin
                        w_write_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (r_x == r_cmd.x1) begin
                        w_x_nxt    = r_cmd.x0;
                        w_y_nxt    = r_y + {{(YW-1){1'b0}}, 1'b1};
                        w_row_nxt  = r_row_base + H_RES_A;
                        w_addr_nxt = w_row_nxt + AVN_AW'(r_cmd.x0);
                    end else begin
                        w_x_nxt    = r_x + {{(XW-1){1'b0}}, 1'b1};
                        w_addr_nxt = r_addr + {{(AVN_AW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end

            ST_DONE: begin
                w_busy_nxt      = 1'b0;
                w_cmd_ready_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
            end

            default: begin
                w_write_nxt     = 1'b0;
                w_busy_nxt      = 1'b0;
                w_cmd_ready_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_row_base  <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_pix_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_row_base  <= w_row_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_pix_cnt   <= w_pix_cnt_nxt;
        end
    end

    assign cmd_ready                  = r_cmd_ready;
    assign busy                       = r_busy;
    assign done                       = r_done;
    assign pixel_count                = r_pix_cnt;
    assign framebuffer_avn_write      = r_write;
    assign framebuffer_avn_read       = 1'b0;
    assign framebuffer_avn_address    = r_addr;
    assign framebuffer_avn_writedata  = r_wdata;
    assign framebuffer_avn_byteenable = {(AVN_DW/8){FULL_BE[0]}};

endmodule
